// File: rtl/fetch_pkg.sv
// Shared state encoding and reset address for the instruction fetch unit.
package fetch_pkg;
    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two synchronous FIFO with flush, occupancy count and combinational head read.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q;
    logic [AW-1:0]    tail_q;
    logic [AW:0]      count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push and pop against the current occupancy.
    always_comb begin
        pop_ok_s  = pop_i && (count_q != '0);
        push_ok_s = push_i && ((count_q < DEPTH_C) || pop_ok_s);
    end

    // Pointer and count update; flush has the same effect as reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok_s) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop_ok_s) begin
                head_q <= head_q + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write port.
    always_ff @(posedge clk_i) begin
        if (push_ok_s && rst_ni && !flush_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[head_q];
    assign count_o     = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request feeding a prefetch FIFO, with branch redirect flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = fetch_pkg::RESET_PC
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] STEP_C  = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] BOOT_C  = {RESET_PC[DATA_WIDTH-1:2], 2'b00};

    fetch_state_t              state_q;
    logic [DATA_WIDTH-1:0]     pc_q;
    logic [DATA_WIDTH-1:0]     req_pc_q;
    logic [DATA_WIDTH-1:0]     target_s;
    logic [CW-1:0]             count_s;
    logic [2*DATA_WIDTH-1:0]   head_s;
    logic                      req_s;
    logic                      push_s;
    logic                      unused_lsb_s;

    assign unused_lsb_s = ^redirect_pc_i[1:0];

    // Request gating and FIFO push qualification.
    always_comb begin
        target_s = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
        req_s    = (state_q == FETCH_REQ) && (count_s < DEPTH_C) && rst_ni;
        push_s   = (state_q == FETCH_WAIT) && imem_rvalid_i && !redirect_i;
    end

    // Fetch FSM; DRAIN swallows the response of a request made stale by a redirect.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= FETCH_REQ;
            pc_q     <= BOOT_C;
            req_pc_q <= BOOT_C;
        end else begin
            case (state_q)
                FETCH_REQ: begin
                    if (req_s && imem_gnt_i) begin
                        if (redirect_i) begin
                            pc_q    <= target_s;
                            state_q <= FETCH_DRAIN;
                        end else begin
                            req_pc_q <= pc_q;
                            pc_q     <= pc_q + STEP_C;
                            state_q  <= FETCH_WAIT;
                        end
                    end else if (redirect_i) begin
                        pc_q <= target_s;
                    end
                end
                FETCH_WAIT: begin
                    if (redirect_i) begin
                        pc_q    <= target_s;
                        state_q <= imem_rvalid_i ? FETCH_REQ : FETCH_DRAIN;
                    end else if (imem_rvalid_i) begin
                        state_q <= FETCH_REQ;
                    end
                end
                FETCH_DRAIN: begin
                    if (redirect_i) begin
                        pc_q <= target_s;
                    end
                    if (imem_rvalid_i) begin
                        state_q <= FETCH_REQ;
                    end
                end
                default: state_q <= FETCH_REQ;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH(2 * DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (redirect_i),
        .push_i     (push_s),
        .push_data_i({req_pc_q, imem_rdata_i}),
        .pop_i      (instr_ready_i),
        .head_data_o(head_s),
        .count_o    (count_s)
    );

    assign imem_req_o    = req_s;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (count_s != '0);
    assign instr_o       = head_s[DATA_WIDTH-1:0];
    assign instr_pc_o    = head_s[2*DATA_WIDTH-1:DATA_WIDTH];
    assign pc_plus4_o    = instr_pc_o + STEP_C;
endmodule

// File: tb/tb_fetch_unit.sv
// Cycle-exact vector table for fetch corner cases, then a randomised streaming run checked by a scoreboard.
module tb_fetch_unit;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [31:0] pc_plus4_o;

    always #5 clk_i = ~clk_i;

    fetch_unit #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH(4),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .pc_plus4_o   (pc_plus4_o)
    );

    typedef struct {
        logic        rst_n;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hC0DE_5000;
    endfunction

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    endfunction

    function automatic void add(input logic rst_n, gnt, rv, input logic [31:0] rdata,
                                input logic rdy, redir, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.rst_n = rst_n; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
        v.redir = redir; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc;
        vq.push_back(v);
    endfunction

    task automatic idle_inputs();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b0;
    endtask

    task automatic run_table();
        foreach (vq[i]) begin
            rst_ni        = vq[i].rst_n;
            imem_gnt_i    = vq[i].gnt;
            imem_rvalid_i = vq[i].rv;
            imem_rdata_i  = vq[i].rdata;
            instr_ready_i = vq[i].rdy;
            redirect_i    = vq[i].redir;
            redirect_pc_i = vq[i].rpc;
            #1;
            chk($sformatf("v%0d_req", i), imem_req_o, vq[i].e_req);
            if (vq[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr_o, vq[i].e_addr);
            chk($sformatf("v%0d_valid", i), instr_valid_o, vq[i].e_valid);
            if (vq[i].e_valid) begin
                chk($sformatf("v%0d_pc", i), instr_pc_o, vq[i].e_pc);
                chk($sformatf("v%0d_instr", i), instr_o, w(vq[i].e_pc));
                chk($sformatf("v%0d_pc4", i), pc_plus4_o, vq[i].e_pc + 32'd4);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic stream_phase();
        logic [31:0] exp_pc;
        logic [31:0] pend_addr;
        logic [31:0] e;
        logic        pend;
        logic        grant;
        int          dly;
        int          grants;
        exp_pc = 32'h0; pend_addr = 32'h0; pend = 1'b0; dly = 0; grants = 0;
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; end
        rst_ni = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 200; c++) begin
            imem_gnt_i    = (c < 24) ? 1'b1 : ((c < 150) ? 1'($urandom_range(0, 1)) : 1'b0);
            instr_ready_i = (c < 24) ? 1'b0 : ($urandom_range(0, 3) != 0);
            imem_rvalid_i = pend && (dly == 0);
            imem_rdata_i  = pend ? w(pend_addr) : 32'h0;
            #1;
            if (c == 24) begin
                chk("fill_req_low", imem_req_o, 32'd0);
                chk("fill_valid", instr_valid_o, 32'd1);
                chk("fill_entries", grants, 32'd4);
            end
            if (instr_valid_o && instr_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("extra_instr_pc", instr_pc_o, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", instr_pc_o, e);
                    chk("sb_instr", instr_o, w(e));
                    chk("sb_pc4", pc_plus4_o, e + 32'd4);
                end
            end
            grant = imem_req_o && imem_gnt_i;
            if (grant) begin
                chk("sb_addr", imem_addr_o, exp_pc);
                exp_q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
                grants++;
            end
            if (imem_rvalid_i) pend = 1'b0;
            else if (pend) dly--;
            if (grant) begin
                pend      = 1'b1;
                pend_addr = imem_addr_o;
                dly       = $urandom_range(0, 2);
            end
            @(posedge clk_i); #1;
        end
        chk("drain_left", exp_q.size(), 32'd0);
        chk("drain_valid", instr_valid_o, 32'd0);
    endtask

    initial begin
        // Streaming from reset: first valid two cycles after release.
        add(L,L,L,Z,L,L,Z, L,Z,L,Z);
        add(H,H,L,Z,L,L,Z, H,32'h0,L,Z);
        add(H,L,H,w(32'h0),L,L,Z, L,Z,L,Z);
        add(H,H,L,Z,H,L,Z, H,32'h4,H,32'h0);
        add(H,L,H,w(32'h4),L,L,Z, L,Z,L,Z);
        add(H,H,L,Z,H,L,Z, H,32'h8,H,32'h4);
        add(H,L,H,w(32'h8),L,L,Z, L,Z,L,Z);
        add(H,L,L,Z,H,L,Z, H,32'hC,H,32'h8);
        // Redirect while waiting; stale response arrives three cycles later.
        add(H,H,L,Z,L,L,Z, H,32'hC,L,Z);
        add(H,L,L,Z,L,H,32'h103, L,Z,L,Z);
        add(H,L,L,Z,L,L,Z, L,Z,L,Z);
        add(H,L,L,Z,L,L,Z, L,Z,L,Z);
        add(H,L,H,w(32'hC),L,L,Z, L,Z,L,Z);
        add(H,H,L,Z,L,L,Z, H,32'h100,L,Z);
        add(H,L,H,w(32'h100),L,L,Z, L,Z,L,Z);
        add(H,L,L,Z,H,L,Z, H,32'h104,H,32'h100);
        // Two buffered, then redirect coinciding with rvalid and pop.
        add(H,H,L,Z,L,L,Z, H,32'h104,L,Z);
        add(H,L,H,w(32'h104),L,L,Z, L,Z,L,Z);
        add(H,H,L,Z,L,L,Z, H,32'h108,H,32'h104);
        add(H,L,H,w(32'h108),L,L,Z, L,Z,H,32'h104);
        add(H,H,L,Z,L,L,Z, H,32'h10C,H,32'h104);
        add(H,L,H,w(32'h10C),H,H,32'h200, L,Z,H,32'h104);
        add(H,L,L,Z,L,L,Z, H,32'h200,L,Z);
        add(H,H,L,Z,L,L,Z, H,32'h200,L,Z);
        add(H,L,H,w(32'h200),L,L,Z, L,Z,L,Z);
        add(H,L,L,Z,H,L,Z, H,32'h204,H,32'h200);
        // Address wrap at the top of the space.
        add(H,L,L,Z,L,H,32'hFFFF_FFFC, H,32'h204,L,Z);
        add(H,H,L,Z,L,L,Z, H,32'hFFFF_FFFC,L,Z);
        add(H,L,H,w(32'hFFFF_FFFC),L,L,Z, L,Z,L,Z);
        add(H,L,L,Z,H,L,Z, H,32'h0,H,32'hFFFF_FFFC);
        // One-cycle reset mid-wait, late response ignored.
        add(H,H,L,Z,L,L,Z, H,32'h0,L,Z);
        add(L,L,L,Z,L,L,Z, L,Z,L,Z);
        add(H,L,H,32'hBAD0_BAD0,L,L,Z, H,32'h0,L,Z);
        add(H,L,L,Z,L,L,Z, H,32'h0,L,Z);
        add(H,H,L,Z,L,L,Z, H,32'h0,L,Z);
        add(H,L,H,w(32'h0),L,L,Z, L,Z,L,Z);
        add(H,L,L,Z,H,L,Z, H,32'h4,H,32'h0);
        // Redirect with grant, then a second redirect while draining.
        add(H,H,L,Z,L,H,32'h300, H,32'h4,L,Z);
        add(H,L,L,Z,L,H,32'h400, L,Z,L,Z);
        add(H,L,H,w(32'h4),L,L,Z, L,Z,L,Z);
        add(H,L,L,Z,L,L,Z, H,32'h400,L,Z);

        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; end
        run_table();
        stream_phase();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, instruction and address width in bits.
REQ-002 Parameter: FIFO_DEPTH, 4, prefetch buffer entries; power of two, minimum 2.
REQ-003 Parameter: RESET_PC, fetch_pkg::RESET_PC (32'h0000_0000), first fetch address after reset.
REQ-004 Port: clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port: rst_ni  input  1  reset, synchronous and active-low.
REQ-006 Port: imem_req_o  output  1  fetch request valid to instruction memory.
REQ-007 Port: imem_addr_o  output  DATA_WIDTH  word-aligned fetch address; [1:0] always 2'b00.
REQ-008 Port: imem_gnt_i  input  1  memory accepts the request in this cycle.
REQ-009 Port: imem_rvalid_i  input  1  response data valid.
REQ-010 Port: imem_rdata_i  input  DATA_WIDTH  fetched instruction word.
REQ-011 Port: redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-012 Port: redirect_pc_i  input  DATA_WIDTH  redirect target; bits [1:0] ignored.
REQ-013 Port: instr_valid_o  output  1  head instruction available to decode.
REQ-014 Port: instr_ready_i  input  1  decode consumes the head entry.
REQ-015 Port: instr_o  output  DATA_WIDTH  head instruction word.
REQ-016 Port: instr_pc_o  output  DATA_WIDTH  address of the head instruction.
REQ-017 Port: pc_plus4_o  output  DATA_WIDTH  instr_pc_o + 4, modulo 2^32; feeds the datapath pc_next input for JAL/JALR link.

Function
REQ-018 FSM states: FETCH_REQ, FETCH_WAIT, FETCH_DRAIN; at most one request outstanding.
REQ-019 imem_req_o = (state==FETCH_REQ) && (count < FIFO_DEPTH) && rst_ni; imem_addr_o = fetch pc.
REQ-020 FETCH_REQ, gnt, no redirect: latch the request pc, pc <= pc+4 (32'hFFFF_FFFC wraps to 0), go to FETCH_WAIT.
REQ-021 FETCH_REQ, gnt with redirect: pc <= redirect target, go to FETCH_DRAIN; no gnt with redirect: pc <= target, stay in FETCH_REQ.
REQ-022 FETCH_WAIT, rvalid, no redirect: push {latched pc, rdata} into FIFO, go to FETCH_REQ.
REQ-023 FETCH_WAIT, rvalid with redirect: discard data, pc <= target, go to FETCH_REQ; redirect without rvalid: pc <= target, go to FETCH_DRAIN.
REQ-024 FETCH_DRAIN: rvalid discarded, go to FETCH_REQ; a further redirect updates pc and stays in FETCH_DRAIN unless rvalid is also high.
REQ-025 imem_rvalid_i in FETCH_REQ is ignored.
REQ-026 instr_valid_o = (count != 0); instr_o and instr_pc_o read combinationally from the FIFO head.
REQ-027 Pop occurs on instr_valid_o && instr_ready_i; pop on empty is ignored; simultaneous push and pop leaves count unchanged.
REQ-028 Redirect empties the FIFO in the same edge (count, head, tail <= 0), overriding push and pop; instr_valid_o is 0 the following cycle.
REQ-029 Latency: rvalid in cycle N gives instr_valid_o in cycle N+1; best case from reset release to first valid instruction is 2 cycles.
REQ-030 The FIFO never overflows: a request issues only when count < FIFO_DEPTH, and count cannot grow while the request is outstanding.

Reset
REQ-031 While rst_ni is low at a clock edge: pc <= RESET_PC, state <= FETCH_REQ, count, head and tail <= 0.
REQ-032 During and after reset: imem_req_o = 0 while rst_ni is low, and instr_valid_o = 0 until the first push.
REQ-033 Reset during FETCH_WAIT abandons the request; a late rvalid is ignored under REQ-025.

Structure
REQ-034 Package fetch_pkg holds typedef enum fetch_state_t {FETCH_REQ, FETCH_WAIT, FETCH_DRAIN} and localparam RESET_PC.
REQ-035 Storage is one sub-module, fetch_fifo: parameterised synchronous FIFO with flush input, count output and combinational head read.

Verification
REQ-036 Reset release, gnt tied high, rvalid one cycle after gnt, ready high -> instr_pc_o sequence 0x0, 0x4, 0x8; pc_plus4_o 0x4, 0x8, 0xC.
REQ-037 ready held low, memory responsive -> exactly 4 entries buffered, imem_req_o drops to 0, no entry lost or duplicated after ready rises.
REQ-038 Redirect to 0x0000_0103 while in FETCH_WAIT, rvalid 3 cycles later -> stale word not delivered; next imem_addr_o is 0x0000_0100 and the first instr_pc_o is 0x100.
REQ-039 Redirect on the same edge as rvalid and as a pop with 2 entries buffered -> FIFO empty, instr_valid_o 0 next cycle, and the next request goes to the target.
REQ-040 Start fetching at pc 0xFFFF_FFFC -> the following imem_addr_o is 0x0000_0000, and pc_plus4_o is 0x0 for the instruction at 0xFFFF_FFFC.
REQ-041 rst_ni low for one cycle mid-FETCH_WAIT, then rvalid -> response ignored, refetch from RESET_PC, instr_valid_o 0 until the new response arrives.
